// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the eight-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting agents and the arbiter.
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    modport master (output req, input gnt, input gnt_idx, input gnt_valid);
    modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);

endinterface

// File: rtl/encoder_8to3.sv
// One-hot to binary encoder; an all-zero input encodes to 0.
module encoder_8to3 (
    input  logic [7:0] in_i,
    output logic [2:0] out_o
);

    always_comb begin
        out_o = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (in_i[i]) begin
                out_o = out_o | 3'(i);
            end
        end
    end

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set bit of v_i searching from p_i upward with wrap.
module rr_pick8 (
    input  logic [7:0] v_i,
    input  logic [2:0] p_i,
    output logic [7:0] sel_o,
    output logic       none_o
);

    logic [7:0] rot;
    logic [7:0] low;

    // Rotate so position p_i lands at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot = 8'h00;
        for (int i = 0; i < 8; i++) begin
            rot[i] = v_i[3'(i) + p_i];
        end
        low = rot & (~rot + 8'd1);
        sel_o = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sel_o[3'(i) + p_i] = low[i];
        end
        none_o = ~|v_i;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and bounded tenure.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic         clk,
    input logic         rst,
    rr_arbiter8_if.slave bus
);
    import arb_pkg::*;

    localparam int unsigned HoldW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HoldW-1:0] hold_q, hold_d;

    logic [N_REQ-1:0] others;
    logic [N_REQ-1:0] pick_v;
    logic [IDX_W-1:0] pick_p;
    logic [N_REQ-1:0] pick_sel;
    logic             pick_none;
    logic [IDX_W-1:0] k;

    assign k      = gnt_idx_q;
    assign others = bus.req & ~gnt_q;
    assign pick_v = (state_q == ARB_IDLE) ? bus.req : others;
    assign pick_p = (state_q == ARB_IDLE) ? ptr_q : k + 3'd1;

    rr_pick8 u_pick (
        .v_i    (pick_v),
        .p_i    (pick_p),
        .sel_o  (pick_sel),
        .none_o (pick_none)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (!pick_none) begin
                    gnt_d   = pick_sel;
                    state_d = ARB_GRANT;
                    hold_d  = '0;
                end
            end
            ARB_GRANT: begin
                if (!bus.req[k]) begin
                    // Release hands over on the same edge, no idle bubble.
                    ptr_d  = k + 3'd1;
                    hold_d = '0;
                    if (!pick_none) begin
                        gnt_d = pick_sel;
                    end else begin
                        gnt_d   = '0;
                        state_d = ARB_IDLE;
                    end
                end else if (pick_none) begin
                    // Sole requester: saturate so it is never preempted.
                    if (hold_q != HoldMax) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else if (hold_q == HoldMax) begin
                    gnt_d  = pick_sel;
                    hold_d = '0;
                    ptr_d  = k + 3'd1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    encoder_8to3 u_enc (
        .in_i  (gnt_d),
        .out_o (gnt_idx_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= |gnt_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a tenure-counting reference model queues expected grants.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    logic [11:0] exp_q[$];

    // Reference model: current holder (-1 none), search start, cycles held so far.
    int m_cur = -1;
    int m_ptr = 0;
    int m_ten = 0;

    function automatic int pick(input logic [7:0] v, input int p);
        for (int i = 0; i < 8; i++) begin
            if (v[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [7:0] q);
        logic [7:0] oth;
        logic [7:0] g;
        if (r) begin
            m_cur = -1;
            m_ptr = 0;
            m_ten = 0;
        end else if (m_cur < 0) begin
            m_cur = pick(q, m_ptr);
            m_ten = (m_cur >= 0) ? 1 : 0;
        end else begin
            oth = q;
            oth[m_cur] = 1'b0;
            if (!q[m_cur]) begin
                m_ptr = (m_cur + 1) % 8;
                m_cur = pick(oth, m_ptr);
                m_ten = (m_cur >= 0) ? 1 : 0;
            end else if (oth == 8'h00) begin
                m_ten = (m_ten < MAX_HOLD) ? m_ten + 1 : MAX_HOLD;
            end else if (m_ten >= MAX_HOLD) begin
                m_ptr = (m_cur + 1) % 8;
                m_cur = pick(oth, m_ptr);
                m_ten = 1;
            end else begin
                m_ten = m_ten + 1;
            end
        end
        g = 8'h00;
        if (m_cur >= 0) g[m_cur] = 1'b1;
        exp_q.push_back({g, 3'((m_cur >= 0) ? m_cur : 0), (m_cur >= 0)});
    endtask

    task automatic cyc(input logic r, input logic [7:0] q);
        @(negedge clk);
        rst     = r;
        bus.req = q;
        model_step(r, q);
    endtask

    // Monitor: one registered result per edge, compared against the oldest expectation.
    initial begin
        logic [11:0] e;
        logic [11:0] got;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.gnt, bus.gnt_idx, bus.gnt_valid};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL grant cyc=%0d got gnt=%h idx=%0d valid=%b required gnt=%h idx=%0d valid=%b",
                             cyc_n, got[11:4], got[3:1], got[0], e[11:4], e[3:1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [7:0] q;
        logic [7:0] flip;
        int         waited;
        rst     = 1'b1;
        bus.req = 8'h00;

        // Reset with all requesting, then first grant after release of reset.
        repeat (3) cyc(1'b1, 8'hFF);
        repeat (2) cyc(1'b0, 8'hFF);

        // Sole requester is never preempted, then drops.
        cyc(1'b1, 8'h00);
        repeat (40) cyc(1'b0, 8'h20);
        repeat (2) cyc(1'b0, 8'h00);

        // Two agents each dropping after two cycles of grant.
        cyc(1'b1, 8'h00);
        for (int i = 0; i < 20; i++) begin
            q = 8'h81;
            if (m_cur >= 0 && m_ten >= 2) q[m_cur] = 1'b0;
            cyc(1'b0, q);
        end

        // Forced rotation under steady contention.
        cyc(1'b1, 8'h00);
        repeat (24) cyc(1'b0, 8'h0C);

        // Wrap-around from index 7.
        cyc(1'b1, 8'h00);
        repeat (2) cyc(1'b0, 8'h80);
        repeat (3) cyc(1'b0, 8'h41);

        // Reset in the middle of a grant.
        cyc(1'b1, 8'h00);
        repeat (2) cyc(1'b0, 8'h10);
        cyc(1'b1, 8'h18);
        repeat (3) cyc(1'b0, 8'h18);

        // Random sticky requests with occasional resets.
        q = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            flip = 8'h00;
            for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(0, 3) == 0);
            q = q ^ flip;
            cyc($urandom_range(0, 99) == 0, q);
        end
        cyc(1'b0, 8'h00);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain got pending=%0d required pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
